// File: rtl/axist_chk_pkg.sv
// rtl/axist_chk_pkg.sv - shared types and constants for the AXI-ST pattern checker
package axist_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam int DATA_W_DEF = 40;
  localparam int ERR_CNT_W  = 16;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axist_sync_fifo.sv
// rtl/axist_sync_fifo.sv - single-clock FIFO with first-word-fall-through head
module axist_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot being written, so push+pop while full is legal.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/axi_st_patchkr_top.sv
// rtl/axi_st_patchkr_top.sv - AXI-ST pattern checker: compares stream beats to expected words
module axi_st_patchkr_top
  import axist_chk_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUS_W     = 256,
  parameter int EXP_DEPTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  input  logic                 chk_en,
  input  logic [8:0]           chk_cnt,
  input  logic                 exp_data_wr,
  input  logic [DATA_W-1:0]    exp_data,
  output logic                 exp_fifo_full,
  input  logic                 axist_valid,
  input  logic [BUS_W-1:0]     axist_data,
  output logic                 axist_rdy,
  output logic [8:0]           rx_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 lane_err,
  output logic                 ovf_err,
  output logic [DATA_W-1:0]    first_err_data,
  output logic                 chk_done,
  output logic                 chk_pass
);

  localparam int NLANE = BUS_W / DATA_W;

  chk_state_e        state;
  chk_state_e        state_nx;
  logic              chk_en_q;
  logic [8:0]        cnt_lim;
  logic              arm;
  logic              beat;
  logic              ovf;
  logic              run_ok;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [NLANE-1:0]  lane_eq;

  logic              s1_vld;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] s1_exp;
  logic              s1_lane_ok;

  generate
    if (BUS_W > NLANE * DATA_W) begin : g_partial_lane
      logic unused_hi;
      assign unused_hi = ^axist_data[BUS_W-1:NLANE*DATA_W];
    end
  endgenerate

  axist_sync_fifo #(
    .DEPTH (EXP_DEPTH),
    .WIDTH (DATA_W)
  ) u_exp_fifo (
    .clk       (rd_clk),
    .rst       (rst),
    .push      (exp_data_wr),
    .push_data (exp_data),
    .pop       (beat),
    .head      (fifo_head),
    .full      (exp_fifo_full),
    .empty     (fifo_empty)
  );

  assign arm       = (state == IDLE) && chk_en && !chk_en_q;
  assign axist_rdy = (state == RUN) && !fifo_empty && (rx_cnt < cnt_lim);
  assign beat      = axist_valid && axist_rdy;
  assign ovf       = exp_data_wr && exp_fifo_full && !beat;
  assign chk_done  = (state == DONE);
  assign run_ok    = (err_cnt == '0) && !lane_err && !ovf_err && !ovf;

  // Only whole lanes take part; lane 0 is the reference for replication.
  always_comb begin
    lane_eq = '1;
    for (int i = 1; i < NLANE; i++) begin
      lane_eq[i] = (axist_data[i*DATA_W +: DATA_W] == axist_data[DATA_W-1:0]);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (arm) state_nx = RUN;
      RUN: begin
        if (!chk_en)                             state_nx = IDLE;
        else if ((rx_cnt == cnt_lim) && !s1_vld) state_nx = DONE;
      end
      DONE:    if (!chk_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state    <= IDLE;
      chk_en_q <= 1'b0;
      chk_pass <= 1'b0;
    end else begin
      state    <= state_nx;
      chk_en_q <= chk_en;
      if (state == RUN && state_nx == DONE) chk_pass <= run_ok;
      else if (state_nx != DONE)            chk_pass <= 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_data    <= '0;
      s1_exp     <= '0;
      s1_lane_ok <= 1'b1;
    end else begin
      s1_vld <= beat;
      if (beat) begin
        s1_data    <= axist_data[DATA_W-1:0];
        s1_exp     <= fifo_head;
        s1_lane_ok <= &lane_eq;
      end
    end
  end

  // Second stage: results land in the counters; an in-flight compare finishes even after abort.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      cnt_lim        <= '0;
      rx_cnt         <= '0;
      err_cnt        <= '0;
      lane_err       <= 1'b0;
      ovf_err        <= 1'b0;
      first_err_data <= '0;
    end else if (arm) begin
      cnt_lim        <= chk_cnt;
      rx_cnt         <= '0;
      err_cnt        <= '0;
      lane_err       <= 1'b0;
      ovf_err        <= 1'b0;
      first_err_data <= '0;
    end else begin
      if (beat) rx_cnt <= rx_cnt + 9'd1;
      if (s1_vld && (s1_data != s1_exp)) begin
        err_cnt <= sat_inc(err_cnt);
        if (err_cnt == '0) first_err_data <= s1_data;
      end
      if (s1_vld && !s1_lane_ok) lane_err <= 1'b1;
      if (ovf)                   ovf_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_st_patchkr_top.sv
// tb/tb_axi_st_patchkr_top.sv - self-checking bench for axi_st_patchkr_top
module tb_axi_st_patchkr_top;

  localparam int DATA_W = 40;
  localparam int BUS_W  = 256;
  localparam int NLANE  = BUS_W / DATA_W;
  localparam logic [DATA_W-1:0] BASE = 40'h11_1111_1111;

  logic              rd_clk = 1'b0;
  logic              rst = 1'b1;
  logic              chk_en = 1'b0;
  logic [8:0]        chk_cnt = '0;
  logic              exp_data_wr = 1'b0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              axist_valid = 1'b0;
  logic [BUS_W-1:0]  axist_data = '0;
  logic              exp_fifo_full;
  logic              axist_rdy;
  logic [8:0]        rx_cnt;
  logic [15:0]       err_cnt;
  logic              lane_err;
  logic              ovf_err;
  logic [DATA_W-1:0] first_err_data;
  logic              chk_done;
  logic              chk_pass;

  axi_st_patchkr_top #(
    .DATA_W    (DATA_W),
    .BUS_W     (BUS_W),
    .EXP_DEPTH (16)
  ) dut (
    .rd_clk         (rd_clk),
    .rst            (rst),
    .chk_en         (chk_en),
    .chk_cnt        (chk_cnt),
    .exp_data_wr    (exp_data_wr),
    .exp_data       (exp_data),
    .exp_fifo_full  (exp_fifo_full),
    .axist_valid    (axist_valid),
    .axist_data     (axist_data),
    .axist_rdy      (axist_rdy),
    .rx_cnt         (rx_cnt),
    .err_cnt        (err_cnt),
    .lane_err       (lane_err),
    .ovf_err        (ovf_err),
    .first_err_data (first_err_data),
    .chk_done       (chk_done),
    .chk_pass       (chk_pass)
  );

  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] sb_q[$];
  int                m_err;
  logic              m_lane;
  logic [DATA_W-1:0] m_first;
  logic [DATA_W-1:0] mon_e;

  // Scoreboard: every accepted beat consumes the oldest expected word.
  always @(posedge rd_clk) begin
    if (!rst && axist_valid && axist_rdy) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: beat accepted, expected queue empty");
      end else begin
        mon_e = sb_q.pop_front();
        if (axist_data[DATA_W-1:0] != mon_e) begin
          if (m_err == 0) m_first = axist_data[DATA_W-1:0];
          m_err++;
        end
        for (int i = 1; i < NLANE; i++)
          if (axist_data[i*DATA_W +: DATA_W] != axist_data[DATA_W-1:0]) m_lane = 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clr();
    m_err   = 0;
    m_lane  = 1'b0;
    m_first = '0;
  endtask

  function automatic logic [BUS_W-1:0] rep(input logic [DATA_W-1:0] w);
    logic [BUS_W-1:0] d;
    d = {BUS_W{1'b0}};
    d[BUS_W-1:BUS_W-32] = $urandom;
    for (int l = 0; l < NLANE; l++) d[l*DATA_W +: DATA_W] = w;
    return d;
  endfunction

  task automatic push_word(input logic [DATA_W-1:0] w, input bit track);
    exp_data_wr = 1'b1;
    exp_data    = w;
    if (track) sb_q.push_back(w);
    @(negedge rd_clk);
    exp_data_wr = 1'b0;
  endtask

  task automatic send_beat(input logic [BUS_W-1:0] d);
    axist_valid = 1'b1;
    axist_data  = d;
    for (int t = 0; t < 64 && !axist_rdy; t++) @(negedge rd_clk);
    if (!axist_rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: axist_rdy got 0 expected 1");
    end
    @(negedge rd_clk);
    axist_valid = 1'b0;
  endtask

  task automatic arm(input int n);
    chk_cnt = 9'(n);
    chk_en  = 1'b1;
    @(negedge rd_clk);
  endtask

  task automatic wait_done(input string nm);
    for (int t = 0; t < 100 && !chk_done; t++) @(negedge rd_clk);
    check({nm, "_done"}, chk_done, 1);
  endtask

  task automatic disarm();
    chk_en = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
  endtask

  typedef struct {
    int nbeat;
    int bad_beat;
    int bad_lane;
    int exp_err;
    bit exp_lane;
    bit exp_pass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [BUS_W-1:0]  d;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] exp_first;

    // bad_lane = -1 corrupts every lane identically, so replication still holds.
    vecs[0] = '{8,  -1,  0, 0, 1'b0, 1'b1};
    vecs[1] = '{8,   3,  0, 1, 1'b1, 1'b0};
    vecs[2] = '{8,   3, -1, 1, 1'b0, 1'b0};
    vecs[3] = '{8,   5,  4, 0, 1'b1, 1'b0};
    vecs[4] = '{1,   0, -1, 1, 1'b0, 1'b0};
    vecs[5] = '{16, 15, -1, 1, 1'b0, 1'b0};

    model_clr();
    repeat (3) @(negedge rd_clk);
    check("rst_rdy", axist_rdy, 0);
    check("rst_rx", rx_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_done", chk_done, 0);
    check("rst_pass", chk_pass, 0);
    check("rst_full", exp_fifo_full, 0);
    rst = 1'b0;
    @(negedge rd_clk);

    for (int v = 0; v < 6; v++) begin
      model_clr();
      base = BASE + DATA_W'(v * 32);
      for (int n = 0; n < vecs[v].nbeat; n++) push_word(base + DATA_W'(n), 1'b1);
      arm(vecs[v].nbeat);
      for (int n = 0; n < vecs[v].nbeat; n++) begin
        d = rep(base + DATA_W'(n));
        if (n == vecs[v].bad_beat) begin
          if (vecs[v].bad_lane < 0) begin
            for (int l = 0; l < NLANE; l++) d[l*DATA_W] = ~d[l*DATA_W];
          end else begin
            d[vecs[v].bad_lane*DATA_W] = ~d[vecs[v].bad_lane*DATA_W];
          end
        end
        send_beat(d);
      end
      wait_done($sformatf("v%0d", v));
      exp_first = (vecs[v].exp_err != 0) ? ((base + DATA_W'(vecs[v].bad_beat)) ^ 40'h1) : '0;
      check($sformatf("v%0d_rx", v), rx_cnt, 64'(vecs[v].nbeat));
      check($sformatf("v%0d_err", v), err_cnt, 64'(vecs[v].exp_err));
      check($sformatf("v%0d_err_model", v), err_cnt, 64'(m_err));
      check($sformatf("v%0d_lane", v), lane_err, vecs[v].exp_lane);
      check($sformatf("v%0d_lane_model", v), lane_err, m_lane);
      check($sformatf("v%0d_first", v), first_err_data, exp_first);
      check($sformatf("v%0d_first_model", v), first_err_data, m_first);
      check($sformatf("v%0d_ovf", v), ovf_err, 0);
      check($sformatf("v%0d_pass", v), chk_pass, vecs[v].exp_pass);
      check($sformatf("v%0d_sb_drained", v), sb_q.size(), 0);
      disarm();
      check($sformatf("v%0d_idle_done", v), chk_done, 0);
    end

    // Valid held against an empty FIFO; a push opens rdy only after the push edge.
    model_clr();
    chk_cnt     = 9'd1;
    chk_en      = 1'b1;
    axist_valid = 1'b1;
    axist_data  = rep(BASE + 40'h77);
    repeat (3) @(negedge rd_clk);
    check("empty_rdy", axist_rdy, 0);
    exp_data_wr = 1'b1;
    exp_data    = BASE + 40'h77;
    sb_q.push_back(BASE + 40'h77);
    check("push_same_cycle_rdy", axist_rdy, 0);
    @(negedge rd_clk);
    exp_data_wr = 1'b0;
    check("push_next_cycle_rdy", axist_rdy, 1);
    @(negedge rd_clk);
    axist_valid = 1'b0;
    check("empty_rx", rx_cnt, 1);
    wait_done("empty");
    check("empty_pass", chk_pass, 1);
    disarm();

    // Zero-length run completes one cycle after entering RUN.
    chk_cnt = 9'd0;
    chk_en  = 1'b1;
    @(negedge rd_clk);
    check("zero_run_done", chk_done, 0);
    @(negedge rd_clk);
    check("zero_done", chk_done, 1);
    check("zero_pass", chk_pass, 1);
    disarm();

    // Overflow: 17 pushes into a 16-deep FIFO, then drain 16 beats.
    model_clr();
    arm(16);
    for (int n = 0; n < 16; n++) push_word(BASE + 40'h100 + DATA_W'(n), 1'b1);
    check("ovf_full", exp_fifo_full, 1);
    check("ovf_not_yet", ovf_err, 0);
    push_word(BASE + 40'h1FF, 1'b0);
    check("ovf_set", ovf_err, 1);
    for (int n = 0; n < 16; n++) send_beat(rep(BASE + 40'h100 + DATA_W'(n)));
    wait_done("ovf");
    check("ovf_rx", rx_cnt, 16);
    check("ovf_err_cnt", err_cnt, 0);
    check("ovf_sticky", ovf_err, 1);
    check("ovf_pass", chk_pass, 0);
    check("ovf_drained_full", exp_fifo_full, 0);
    disarm();

    // Reset after 4 of 8 beats, then a clean 2-beat run.
    model_clr();
    for (int n = 0; n < 8; n++) push_word(BASE + 40'h200 + DATA_W'(n), 1'b1);
    arm(8);
    for (int n = 0; n < 4; n++) send_beat(rep(BASE + 40'h200 + DATA_W'(n)));
    check("pre_rst_rx", rx_cnt, 4);
    rst    = 1'b1;
    chk_en = 1'b0;
    @(negedge rd_clk);
    sb_q.delete();
    check("mid_rst_rdy", axist_rdy, 0);
    check("mid_rst_rx", rx_cnt, 0);
    check("mid_rst_err", err_cnt, 0);
    check("mid_rst_lane", lane_err, 0);
    check("mid_rst_ovf", ovf_err, 0);
    check("mid_rst_first", first_err_data, 0);
    check("mid_rst_done", chk_done, 0);
    check("mid_rst_pass", chk_pass, 0);
    rst = 1'b0;
    @(negedge rd_clk);
    model_clr();
    push_word(BASE + 40'h300, 1'b1);
    push_word(BASE + 40'h301, 1'b1);
    arm(2);
    send_beat(rep(BASE + 40'h300));
    send_beat(rep(BASE + 40'h301));
    wait_done("rearm");
    check("rearm_rx", rx_cnt, 2);
    check("rearm_err", err_cnt, 0);
    check("rearm_pass", chk_pass, 1);
    disarm();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
